// File: rtl/apb_event_master.sv
// APB write master that counts pulses on NUM_EVENTS event inputs and drains one
// count per APB write to a per-channel address, with fixed or round-robin arbitration.
module apb_event_master #(
  parameter int          NUM_EVENTS   = 3,
  parameter int          CNT_W        = 4,
  parameter int          DATA_W       = 32,
  parameter logic [31:0] BASE_ADDR    = 32'hA000_0000,
  parameter logic [31:0] ADDR_STRIDE  = 32'h0001_0000,
  parameter int          ARB_MODE     = 0,
  parameter int          RETRY_ON_ERR = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic [NUM_EVENTS-1:0] overflow_clr_i,
  output logic                  apb_psel_o,
  output logic                  apb_penable_o,
  output logic [31:0]           apb_paddr_o,
  output logic                  apb_pwrite_o,
  output logic [DATA_W-1:0]     apb_pwdata_o,
  input  logic                  apb_pready_i,
  input  logic                  apb_pslverr_i,
  output logic [NUM_EVENTS-1:0] overflow_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int IDX_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                           state_q, state_d;
  logic [NUM_EVENTS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_EVENTS-1:0]            overflow_q, overflow_d;
  logic [IDX_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [31:0]                      paddr_q, paddr_d;
  logic [DATA_W-1:0]                pwdata_q, pwdata_d;
  logic                             psel_q, psel_d;
  logic                             penable_q, penable_d;
  logic                             err_q, err_d;

  logic                  any_pending;
  logic                  grant;
  logic [IDX_W-1:0]      fixed_idx;
  logic [IDX_W-1:0]      rr_idx;
  logic                  rr_found;
  logic [IDX_W-1:0]      grant_idx;
  logic [NUM_EVENTS-1:0] dec;
  logic [DATA_W-1:0]     cnt_sum;

  // Pending summary and total of all counters as they stand this cycle.
  always_comb begin
    any_pending = 1'b0;
    cnt_sum     = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (cnt_q[i] != '0) any_pending = 1'b1;
      cnt_sum = cnt_sum + DATA_W'(cnt_q[i]);
    end
  end

  // Both arbiters are evaluated; ARB_MODE picks which one drives the grant.
  always_comb begin
    fixed_idx = '0;
    rr_idx    = '0;
    rr_found  = 1'b0;
    for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
      if (cnt_q[i] != '0) fixed_idx = IDX_W'(i);
    end
    for (int k = 1; k <= NUM_EVENTS; k++) begin
      if (!rr_found && cnt_q[(int'(rr_ptr_q) + k) % NUM_EVENTS] != '0) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'((int'(rr_ptr_q) + k) % NUM_EVENTS);
      end
    end
  end

  assign grant_idx = (ARB_MODE == 1) ? rr_idx : fixed_idx;

  // Transfer sequencing: IDLE -> SETUP -> ACCESS, with back-to-back and retry paths.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    err_d    = 1'b0;
    rr_ptr_d = rr_ptr_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    case (state_q)
      ST_IDLE: begin
        if (any_pending) begin
          grant   = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (apb_pready_i) begin
          err_d = apb_pslverr_i;
          if (apb_pslverr_i && RETRY_ON_ERR != 0) begin
            state_d = ST_SETUP;
          end else if (any_pending) begin
            grant   = 1'b1;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (grant) begin
      paddr_d = BASE_ADDR + 32'(grant_idx) * ADDR_STRIDE;
      // The granted counter is nonzero, so the post-decrement total is sum-1.
      pwdata_d = cnt_sum - DATA_W'(1);
      if (ARB_MODE == 1) rr_ptr_d = grant_idx;
    end
    psel_d    = (state_d != ST_IDLE);
    penable_d = (state_d == ST_ACCESS);
  end

  assign dec = grant ? (NUM_EVENTS'(1) << grant_idx) : '0;

  // Saturating counters; a same-cycle set of the sticky flag beats its clear.
  always_comb begin
    cnt_d      = cnt_q;
    overflow_d = overflow_q & ~overflow_clr_i;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (event_i[i] && !dec[i]) begin
        if (cnt_q[i] == CNT_MAX) overflow_d[i] = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec[i] && !event_i[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      overflow_q <= '0;
      rr_ptr_q   <= IDX_W'(NUM_EVENTS - 1);
      paddr_q    <= '0;
      pwdata_q   <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      rr_ptr_q   <= rr_ptr_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      err_q      <= err_d;
    end
  end

  assign apb_psel_o    = psel_q;
  assign apb_penable_o = penable_q;
  assign apb_paddr_o   = paddr_q;
  assign apb_pwrite_o  = 1'b1;
  assign apb_pwdata_o  = pwdata_q;
  assign overflow_o    = overflow_q;
  assign err_o         = err_q;
  assign busy_o        = psel_q;

endmodule

// File: tb/tb_apb_event_master.sv
// Directed bench for apb_event_master: three instances (fixed/retry, round-robin/retry,
// fixed/drop) with a transfer scoreboard of expected {paddr, pwdata} pairs.
module tb_apb_event_master;

  logic        clk;
  logic        rst_n;
  logic [2:0]  ev      [3];
  logic [2:0]  clr     [3];
  logic        pready  [3];
  logic        pslverr [3];
  logic        psel    [3];
  logic        pen     [3];
  logic        pwrite  [3];
  logic        err     [3];
  logic        busy    [3];
  logic [31:0] paddr   [3];
  logic [31:0] pwdata  [3];
  logic [2:0]  ovf     [3];

  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  int          cur;
  int          n_vec;
  int          n_err;

  apb_event_master #(.ARB_MODE(0), .RETRY_ON_ERR(1)) dut_fix (
    .clk(clk), .reset(rst_n), .event_i(ev[0]), .overflow_clr_i(clr[0]),
    .apb_psel_o(psel[0]), .apb_penable_o(pen[0]), .apb_paddr_o(paddr[0]),
    .apb_pwrite_o(pwrite[0]), .apb_pwdata_o(pwdata[0]), .apb_pready_i(pready[0]),
    .apb_pslverr_i(pslverr[0]), .overflow_o(ovf[0]), .err_o(err[0]), .busy_o(busy[0]));

  apb_event_master #(.ARB_MODE(1), .RETRY_ON_ERR(1)) dut_rr (
    .clk(clk), .reset(rst_n), .event_i(ev[1]), .overflow_clr_i(clr[1]),
    .apb_psel_o(psel[1]), .apb_penable_o(pen[1]), .apb_paddr_o(paddr[1]),
    .apb_pwrite_o(pwrite[1]), .apb_pwdata_o(pwdata[1]), .apb_pready_i(pready[1]),
    .apb_pslverr_i(pslverr[1]), .overflow_o(ovf[1]), .err_o(err[1]), .busy_o(busy[1]));

  apb_event_master #(.ARB_MODE(0), .RETRY_ON_ERR(0)) dut_drop (
    .clk(clk), .reset(rst_n), .event_i(ev[2]), .overflow_clr_i(clr[2]),
    .apb_psel_o(psel[2]), .apb_penable_o(pen[2]), .apb_paddr_o(paddr[2]),
    .apb_pwrite_o(pwrite[2]), .apb_pwdata_o(pwdata[2]), .apb_pready_i(pready[2]),
    .apb_pslverr_i(pslverr[2]), .overflow_o(ovf[2]), .err_o(err[2]), .busy_o(busy[2]));

  // Clock and reset-time defaults.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_idle(input int d, input int max, input string tag);
    for (int i = 0; i < max && busy[d]; i++) tick();
    chk(tag, 64'(busy[d]), 64'd0);
  endtask

  task automatic wait_access(input int d, input int max, input string tag);
    for (int i = 0; i < max && !(psel[d] && pen[d]); i++) tick();
    chk(tag, 64'(psel[d] && pen[d]), 64'd1);
  endtask

  // A transfer completes at the next rising edge when PSEL, PENABLE and PREADY
  // are all high here, just after the falling edge when inputs have settled.
  always @(negedge clk) begin
    #1;
    if (rst_n && psel[cur] && pen[cur] && pready[cur]) begin
      mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      chk("xfer", {paddr[cur], pwdata[cur]}, mon_exp);
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    cur   = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      ev[d] = '0; clr[d] = '0; pready[d] = 1'b1; pslverr[d] = 1'b0;
    end
    ticks(2);
    chk("rst_psel",    64'(psel[0]),   64'd0);
    chk("rst_penable", 64'(pen[0]),    64'd0);
    chk("rst_paddr",   64'(paddr[0]),  64'd0);
    chk("rst_pwdata",  64'(pwdata[0]), 64'd0);
    chk("rst_pwrite",  64'(pwrite[0]), 64'd1);
    chk("rst_ovf",     64'(ovf[0]),    64'd0);
    chk("rst_err",     64'(err[0]),    64'd0);
    chk("rst_busy",    64'(busy[0]),   64'd0);
    rst_n = 1'b1;
    ticks(2);

    // Single event on channel 1.
    cur = 0;
    exp_q.push_back({32'hA001_0000, 32'd0});
    ev[0] = 3'b010;
    tick();
    ev[0] = 3'b000;
    chk("t1_psel_e1", 64'(psel[0]), 64'd0);
    tick();
    chk("t1_setup_psel", 64'(psel[0]), 64'd1);
    chk("t1_setup_pen",  64'(pen[0]),  64'd0);
    chk("t1_paddr",      64'(paddr[0]), 64'hA001_0000);
    chk("t1_pwdata",     64'(pwdata[0]), 64'd0);
    tick();
    chk("t1_access_psel", 64'(psel[0]), 64'd1);
    chk("t1_access_pen",  64'(pen[0]),  64'd1);
    tick();
    chk("t1_idle_psel", 64'(psel[0]), 64'd0);
    chk("t1_idle_busy", 64'(busy[0]), 64'd0);
    ticks(2);

    // All three channels at once, fixed priority, back-to-back.
    exp_q.push_back({32'hA000_0000, 32'd2});
    exp_q.push_back({32'hA001_0000, 32'd1});
    exp_q.push_back({32'hA002_0000, 32'd0});
    ev[0] = 3'b111;
    tick();
    ev[0] = 3'b000;
    tick();
    chk("t2_busy", 64'(busy[0]), 64'd1);
    tick();
    tick();
    chk("t2_b2b_psel", 64'(psel[0]), 64'd1);
    chk("t2_b2b_pen",  64'(pen[0]),  64'd0);
    wait_idle(0, 20, "t2_idle_timeout");
    chk("t2_drained", 64'(exp_q.size()), 64'd0);
    ticks(2);

    // Round-robin with channel 0 held high for six cycles.
    cur = 1;
    exp_q.push_back({32'hA000_0000, 32'd2});
    exp_q.push_back({32'hA001_0000, 32'd3});
    exp_q.push_back({32'hA002_0000, 32'd4});
    exp_q.push_back({32'hA000_0000, 32'd4});
    exp_q.push_back({32'hA000_0000, 32'd3});
    exp_q.push_back({32'hA000_0000, 32'd2});
    exp_q.push_back({32'hA000_0000, 32'd1});
    exp_q.push_back({32'hA000_0000, 32'd0});
    ev[1] = 3'b111;
    tick();
    ev[1] = 3'b001;
    ticks(5);
    ev[1] = 3'b000;
    wait_idle(1, 40, "t3_idle_timeout");
    chk("t3_drained", 64'(exp_q.size()), 64'd0);
    ticks(2);

    // Five wait states in ACCESS.
    cur = 0;
    exp_q.push_back({32'hA002_0000, 32'd0});
    pready[0] = 1'b0;
    ev[0] = 3'b100;
    tick();
    ev[0] = 3'b000;
    wait_access(0, 10, "t4_access_timeout");
    for (int i = 0; i < 6; i++) begin
      chk("t4_hold_psel",   64'(psel[0]),   64'd1);
      chk("t4_hold_pen",    64'(pen[0]),    64'd1);
      chk("t4_hold_paddr",  64'(paddr[0]),  64'hA002_0000);
      chk("t4_hold_pwdata", 64'(pwdata[0]), 64'd0);
      if (i < 5) tick();
    end
    pready[0] = 1'b1;
    tick();
    chk("t4_done_psel", 64'(psel[0]), 64'd0);
    chk("t4_drained", 64'(exp_q.size()), 64'd0);
    ticks(2);

    // PSLVERR with retry: the same transfer repeats before channel 1 is served.
    exp_q.push_back({32'hA000_0000, 32'd1});
    exp_q.push_back({32'hA000_0000, 32'd1});
    exp_q.push_back({32'hA001_0000, 32'd0});
    pslverr[0] = 1'b1;
    ev[0] = 3'b011;
    tick();
    ev[0] = 3'b000;
    wait_access(0, 10, "t5r_access_timeout");
    tick();
    pslverr[0] = 1'b0;
    chk("t5r_err_pulse", 64'(err[0]),    64'd1);
    chk("t5r_setup_pen", 64'(pen[0]),    64'd0);
    chk("t5r_paddr",     64'(paddr[0]),  64'hA000_0000);
    chk("t5r_pwdata",    64'(pwdata[0]), 64'd1);
    tick();
    chk("t5r_err_low", 64'(err[0]), 64'd0);
    wait_idle(0, 20, "t5r_idle_timeout");
    chk("t5r_drained", 64'(exp_q.size()), 64'd0);
    ticks(2);

    // PSLVERR with drop: the errored count is not restored.
    cur = 2;
    exp_q.push_back({32'hA000_0000, 32'd1});
    exp_q.push_back({32'hA001_0000, 32'd0});
    pslverr[2] = 1'b1;
    ev[2] = 3'b011;
    tick();
    ev[2] = 3'b000;
    wait_access(2, 10, "t5d_access_timeout");
    tick();
    pslverr[2] = 1'b0;
    chk("t5d_err_pulse", 64'(err[2]),    64'd1);
    chk("t5d_paddr",     64'(paddr[2]),  64'hA001_0000);
    chk("t5d_pwdata",    64'(pwdata[2]), 64'd0);
    wait_idle(2, 20, "t5d_idle_timeout");
    ticks(4);
    chk("t5d_stay_idle", 64'(busy[2]), 64'd0);
    chk("t5d_drained", 64'(exp_q.size()), 64'd0);

    // Saturation with PREADY low, then reset in the middle of ACCESS.
    cur = 0;
    pready[0] = 1'b0;
    ev[0] = 3'b001;
    ticks(16);
    chk("t6_no_ovf_yet", 64'(ovf[0]), 64'd0);
    ticks(2);
    clr[0] = 3'b001;
    tick();
    clr[0] = 3'b000;
    chk("t6_set_beats_clr", 64'(ovf[0]), 64'd1);
    tick();
    ev[0] = 3'b000;
    chk("t6_ovf_sticky", 64'(ovf[0]), 64'd1);
    chk("t6_still_access", 64'(psel[0] && pen[0]), 64'd1);
    clr[0] = 3'b001;
    tick();
    clr[0] = 3'b000;
    chk("t6_ovf_cleared", 64'(ovf[0]), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_psel", 64'(psel[0]), 64'd0);
    chk("t6_rst_pen",  64'(pen[0]),  64'd0);
    chk("t6_rst_busy", 64'(busy[0]), 64'd0);
    tick();
    rst_n = 1'b1;
    pready[0] = 1'b1;
    ticks(4);
    chk("t6_counts_cleared", 64'(busy[0]), 64'd0);
    chk("final_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
